// File: rtl/sha256_compress_core_if.sv
// Request/result bundle between the block padder and the SHA-256 compression core.
// No timing of its own; signal timing is set by the core.
// Backpressure is busy: start is only sampled while busy is low, no queueing.
//
// Signals:
//   start     padder -> core  request to compress one block
//   block_in  padder -> core  512-bit block, W0 in [511:480] ... W15 in [31:0]
//   hash_in   padder -> core  256-bit chaining value, H0 in [255:224] ... H7 in [31:0]
//   busy      core -> padder  a block is in flight
//   done      core -> padder  one-cycle pulse, hash_out updated
//   hash_out  core -> padder  result, same packing as hash_in, held until next done
interface sha256_compress_core_if;
  logic         start;
  logic [511:0] block_in;
  logic [255:0] hash_in;
  logic         busy;
  logic         done;
  logic [255:0] hash_out;

  modport master (
    output start, block_in, hash_in,
    input  busy, done, hash_out
  );

  modport slave (
    input  start, block_in, hash_in,
    output busy, done, hash_out
  );
endinterface

// File: rtl/sha256_compress_core.sv
// Iterative SHA-256 compression: one round per clock, 16-word rolling message schedule.
// Latency: start accepted in cycle 0 -> done pulse in cycle ROUNDS+2 (66 for SHA-256).
// Backpressure: busy high from cycle 1 through FINAL; start while busy is dropped.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of sha256_compress_core_if (start/block_in/hash_in in,
//          busy/done/hash_out out)
module sha256_compress_core #(
  parameter int ROUNDS = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sha256_compress_core_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Rotation by a constant amount reduces to wiring.
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] dbl;
    dbl = {x, x} >> n;
    return dbl[31:0];
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t      state_q, state_d;
  logic [6:0]  t_q, t_d;
  logic [31:0] v_q [8];      // working variables a..h, v_q[0] = a
  logic [31:0] v_d [8];
  logic [31:0] w_q [16];     // schedule window, w_q[0] is W[t]
  logic [31:0] w_d [16];
  logic [31:0] hsav_q [8];   // chaining value captured at start
  logic [31:0] hsav_d [8];
  logic [255:0] hash_q, hash_d;
  logic        done_q, done_d;

  logic [31:0] ch, maj, t1, t2, w_next;

  assign ch     = (v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]);
  assign maj    = (v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]);
  assign t1     = v_q[7] + big_sigma1(v_q[4]) + ch + K[t_q[5:0]] + w_q[0];
  assign t2     = big_sigma0(v_q[0]) + maj;
  // W[t+16] lands in the top slot as the window slides down one word.
  assign w_next = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    v_d     = v_q;
    w_d     = w_q;
    hsav_d  = hsav_q;
    hash_d  = hash_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < 16; i++) w_d[i] = bus.block_in[511 - 32*i -: 32];
          for (int i = 0; i < 8; i++) begin
            v_d[i]    = bus.hash_in[255 - 32*i -: 32];
            hsav_d[i] = bus.hash_in[255 - 32*i -: 32];
          end
          t_d     = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        v_d[7] = v_q[6];
        v_d[6] = v_q[5];
        v_d[5] = v_q[4];
        v_d[4] = v_q[3] + t1;
        v_d[3] = v_q[2];
        v_d[2] = v_q[1];
        v_d[1] = v_q[0];
        v_d[0] = t1 + t2;
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = w_next;
        t_d     = t_q + 7'd1;
        if (t_q == LAST_T) state_d = FINAL;
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) hash_d[255 - 32*i -: 32] = hsav_q[i] + v_q[i];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      hash_q  <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        v_q[i]    <= '0;
        hsav_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      hash_q  <= hash_d;
      done_q  <= done_d;
      v_q     <= v_d;
      hsav_q  <= hsav_d;
      w_q     <= w_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.hash_out = hash_q;

endmodule

// File: tb/tb_sha256_compress_core.sv
module tb_sha256_compress_core;

  localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'd0, 32'h00000018};
  localparam logic [511:0] BLK_EMP = {32'h80000000, 480'd0};
  localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam int NRAND = 500;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  sha256_compress_core_if bus ();

  sha256_compress_core #(.ROUNDS(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic done_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // done must never be high in two consecutive cycles.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      check_eq("done_width", {255'd0, done_prev}, 256'd0);
      done_cnt++;
    end
    done_prev = bus.done;
  end

  // Reference: full 64-entry schedule expanded up front, then 64 rounds.
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] model(input logic [511:0] blk, input logic [255:0] hin);
    logic [31:0] w [64];
    logic [31:0] h [8];
    logic [31:0] a, b, c, d, e, f, g, hh, s0, s1, x1, x2;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) h[i] = hin[255 - 32*i -: 32];
    a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
    for (int t = 0; t < 64; t++) begin
      x1 = hh + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
      x2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + x1; d = c; c = b; b = a; a = x1 + x2;
    end
    r = {h[0] + a, h[1] + b, h[2] + c, h[3] + d, h[4] + e, h[5] + f, h[6] + g, h[7] + hh};
    return r;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [255:0] rand_hash();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = $urandom();
    return r;
  endfunction

  // Called in cycle 0 (just after an edge); returns in the done cycle.
  task automatic run_block(input logic [511:0] blk, input logic [255:0] h,
                           output logic [255:0] res, output int lat);
    bus.block_in = blk;
    bus.hash_in  = h;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.block_in = rand_block();
    bus.hash_in  = rand_hash();
    lat = -1;
    res = '0;
    for (int c = 1; c <= 80; c++) begin
      if (c == 1) check_eq("busy_c1", {255'd0, bus.busy}, 256'd1);
      if (bus.done === 1'b1) begin
        lat = c;
        res = bus.hash_out;
        check_eq("busy_done", {255'd0, bus.busy}, 256'd0);
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [255:0] res, exp;
    int lat, d0, dcnt;

    bus.start = 1'b0;
    bus.block_in = '0;
    bus.hash_in = '0;
    #1;
    check_eq("rst_busy", {255'd0, bus.busy}, 256'd0);
    check_eq("rst_done", {255'd0, bus.done}, 256'd0);
    check_eq("rst_hash", bus.hash_out, 256'd0);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // "abc" and empty message
    run_block(BLK_ABC, IV, res, lat);
    check_eq("abc_lat", 256'(lat), 256'd66);
    check_eq("abc_hash", res, DIG_ABC);
    run_block(BLK_EMP, IV, res, lat);
    check_eq("emp_lat", 256'(lat), 256'd66);
    check_eq("emp_hash", res, DIG_EMP);
    @(posedge clk); #1;
    check_eq("hash_held", bus.hash_out, DIG_EMP);

    // start while busy is ignored
    d0 = done_cnt;
    bus.block_in = BLK_ABC; bus.hash_in = IV; bus.start = 1'b1;
    @(posedge clk); #1;
    lat = -1; res = '0;
    for (int c = 1; c <= 80; c++) begin
      bus.start = (c == 10 || c == 40);
      if (bus.start) bus.block_in = rand_block();
      if (bus.done === 1'b1 && lat < 0) begin lat = c; res = bus.hash_out; end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    check_eq("busy_start_lat", 256'(lat), 256'd66);
    check_eq("busy_start_hash", res, DIG_ABC);
    check_eq("busy_start_ndone", 256'(done_cnt - d0), 256'd1);

    // reset mid-run
    bus.block_in = BLK_EMP; bus.hash_in = IV; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", {255'd0, bus.busy}, 256'd0);
    check_eq("mid_rst_done", {255'd0, bus.done}, 256'd0);
    check_eq("mid_rst_hash", bus.hash_out, 256'd0);
    #2 rst_n = 1'b1;
    d0 = done_cnt;
    repeat (80) @(posedge clk);
    #1;
    check_eq("mid_rst_nodone", 256'(done_cnt - d0), 256'd0);
    run_block(BLK_ABC, IV, res, lat);
    check_eq("post_rst_lat", 256'(lat), 256'd66);
    check_eq("post_rst_hash", res, DIG_ABC);

    // start held high, chained back-to-back
    bus.block_in = BLK_ABC; bus.hash_in = IV; bus.start = 1'b1;
    dcnt = 0;
    for (int c = 1; c <= 140; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        if (dcnt == 0) begin
          check_eq("b2b_lat1", 256'(c), 256'd66);
          check_eq("b2b_hash1", bus.hash_out, DIG_ABC);
          bus.hash_in  = bus.hash_out;
          bus.block_in = BLK_EMP;
        end else if (dcnt == 1) begin
          check_eq("b2b_lat2", 256'(c), 256'd132);
          check_eq("b2b_hash2", bus.hash_out, model(BLK_EMP, DIG_ABC));
          bus.start = 1'b0;
        end
        dcnt++;
      end
    end
    bus.start = 1'b0;
    check_eq("b2b_ndone", 256'(dcnt), 256'd2);
    @(posedge clk); #1;

    // random blocks, each started in the previous done cycle
    for (int n = 0; n < NRAND; n++) begin
      logic [511:0] blk;
      logic [255:0] h;
      blk = rand_block();
      h   = rand_hash();
      exp = model(blk, h);
      run_block(blk, h, res, lat);
      check_eq("rand_lat", 256'(lat), 256'd66);
      check_eq("rand_hash", res, exp);
    end

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
